// File: rtl/tile_dispatcher.sv
// Single-tile buffer between the BRAM tile reader and the CNN / lite paths.
// Optional per-path tile counters are built only when TILE_DISPATCH_STATS_EN is defined.
module tile_dispatcher #(
    parameter int DATA_WIDTH  = 8,
    parameter int TILE_WIDTH  = 16,
    parameter int TILE_HEIGHT = 16
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic [DATA_WIDTH-1:0] iData,
    input  logic                  iValid,
    output logic                  oInReady,
    input  logic                  iRouteToCnn,
    input  logic                  iDecisionValid,
    output logic [DATA_WIDTH-1:0] oCnnData,
    output logic                  oCnnValid,
    output logic                  oCnnLast,
    input  logic                  iCnnReady,
    output logic [DATA_WIDTH-1:0] oLiteData,
    output logic                  oLiteValid,
    output logic                  oLiteLast,
    input  logic                  iLiteReady,
    output logic                  oBusy,
    output logic                  oOverflow,
    output logic                  oDecErr,
    output logic [15:0]           oCnnTileCnt,
    output logic [15:0]           oLiteTileCnt
);
    localparam int TILE_PIXELS = TILE_WIDTH * TILE_HEIGHT;
    localparam int PTR_W       = (TILE_PIXELS > 1) ? $clog2(TILE_PIXELS) : 1;
    localparam int CNT_W       = $clog2(TILE_PIXELS + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(TILE_PIXELS - 1);
    localparam logic [CNT_W-1:0] PIX_CNT  = CNT_W'(TILE_PIXELS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TILE_PIXELS - 1);

    typedef enum logic [1:0] {IDLE, FILL, WAIT_DEC, DRAIN} state_t;

    state_t                  state;
    state_t                  stateNext;
    logic [DATA_WIDTH-1:0]   tileMem [TILE_PIXELS];
    logic [PTR_W-1:0]        wrPtr;
    logic [CNT_W-1:0]        rdCnt;
    logic                    decLatched;
    logic                    decCnn;
    logic                    inRdy;
    logic                    overflow;
    logic                    decErr;
    logic [DATA_WIDTH-1:0]   outData_p1;
    logic                    vld_p1;
    logic                    outLast_p1;

    logic accept;
    logic lastWrite;
    logic decAccept;
    logic outReady;
    logic outFire;
    logic lastFire;
    logic loadNext;

    assign accept    = iValid & inRdy;
    assign lastWrite = accept & (wrPtr == LAST_PTR);
    assign decAccept = iDecisionValid & ~decLatched & ((state == FILL) || (state == WAIT_DEC));
    assign outReady  = decCnn ? iCnnReady : iLiteReady;
    assign outFire   = vld_p1 & outReady;
    assign lastFire  = outFire & outLast_p1;
    // Refill the output register whenever it is empty or being consumed, until the tile is exhausted.
    assign loadNext  = (state == DRAIN) & (~vld_p1 | outReady) & (rdCnt < PIX_CNT);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (lastWrite)   stateNext = WAIT_DEC;
                else if (accept) stateNext = FILL;
            end
            FILL: begin
                if (lastWrite) stateNext = (decLatched | decAccept) ? DRAIN : WAIT_DEC;
            end
            WAIT_DEC: begin
                if (decAccept) stateNext = DRAIN;
            end
            DRAIN: begin
                if (lastFire) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state      <= IDLE;
            inRdy      <= 1'b0;
            wrPtr      <= '0;
            rdCnt      <= '0;
            decLatched <= 1'b0;
            decCnn     <= 1'b0;
            vld_p1     <= 1'b0;
            outLast_p1 <= 1'b0;
            overflow   <= 1'b0;
            decErr     <= 1'b0;
        end else begin
            state <= stateNext;
            inRdy <= (stateNext == IDLE) || (stateNext == FILL);

            if (lastWrite)   wrPtr <= '0;
            else if (accept) wrPtr <= wrPtr + 1'b1;

            if (lastFire)      rdCnt <= '0;
            else if (loadNext) rdCnt <= rdCnt + 1'b1;

            if (lastFire) begin
                decLatched <= 1'b0;
                decCnn     <= 1'b0;
            end else if (decAccept) begin
                decLatched <= 1'b1;
                decCnn     <= iRouteToCnn;
            end

            if (loadNext) begin
                vld_p1     <= 1'b1;
                outLast_p1 <= (rdCnt == LAST_CNT);
            end else if (outFire) begin
                vld_p1     <= 1'b0;
                outLast_p1 <= 1'b0;
            end

            if (iValid & ~inRdy) overflow <= 1'b1;
            if (iDecisionValid & ((state == IDLE) || (state == DRAIN))) decErr <= 1'b1;
        end
    end

    // Stage p0 -> p1: tile buffer write and synchronous prefetch read into the output register
    always_ff @(posedge iClk) begin
        if (accept)   tileMem[wrPtr] <= iData;
        if (loadNext) outData_p1     <= tileMem[rdCnt[PTR_W-1:0]];
    end

    assign oInReady   = inRdy;
    assign oBusy      = (state != IDLE);
    assign oOverflow  = overflow;
    assign oDecErr    = decErr;
    assign oCnnValid  = vld_p1 & decCnn;
    assign oCnnLast   = vld_p1 & decCnn & outLast_p1;
    assign oCnnData   = (vld_p1 & decCnn) ? outData_p1 : '0;
    assign oLiteValid = vld_p1 & ~decCnn;
    assign oLiteLast  = vld_p1 & ~decCnn & outLast_p1;
    assign oLiteData  = (vld_p1 & ~decCnn) ? outData_p1 : '0;

`ifdef TILE_DISPATCH_STATS_EN
    logic [15:0] cnnTiles;
    logic [15:0] liteTiles;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            cnnTiles  <= '0;
            liteTiles <= '0;
        end else if (lastFire) begin
            if (decCnn) cnnTiles  <= cnnTiles + 16'd1;
            else        liteTiles <= liteTiles + 16'd1;
        end
    end

    assign oCnnTileCnt  = cnnTiles;
    assign oLiteTileCnt = liteTiles;
`else
    assign oCnnTileCnt  = '0;
    assign oLiteTileCnt = '0;
`endif

endmodule
